// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing the data memory between the LSU (port 0) and the debug loader (port 1)
// Define DATA_MEM_ARB_BOUNDS_CHECK_EN to add out-of-range detection on err0_o/err1_o.
module data_mem_arbiter #(
  parameter  int unsigned MEM_SIZE_BYTES = 2048,
  localparam int unsigned MEM_SIZE_WORDS = MEM_SIZE_BYTES / 4,
  localparam int unsigned IDX_W          = $clog2(MEM_SIZE_WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic             we0_i,
  input  logic [31:0]      addr0_i,
  input  logic [3:0]       be0_i,
  input  logic [31:0]      wdata0_i,
  input  logic             req1_i,
  input  logic             we1_i,
  input  logic [31:0]      addr1_i,
  input  logic [3:0]       be1_i,
  input  logic [31:0]      wdata1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             rvalid0_o,
  output logic             rvalid1_o,
  output logic [31:0]      rdata0_o,
  output logic [31:0]      rdata1_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [IDX_W-1:0] mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [31:0]      mem_wdata_o,
`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
  output logic             err0_o,
  output logic             err1_o,
`endif
  input  logic [31:0]      mem_rdata_i
);

  localparam int unsigned OFS_W = $clog2(MEM_SIZE_BYTES);

  // last_grant = 1 means port 1 was served last, so port 0 has priority
  logic        last_grant;
  logic        resp_valid;
  logic        resp_owner;
  logic        resp_read;
  logic        resp_err;

  logic        any_gnt;
  logic        sel1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic        oob;
  logic        unused_addr_bits;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (!rst_i) begin
      if (req0_i && req1_i) begin
        gnt0_o = last_grant;
        gnt1_o = !last_grant;
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  assign any_gnt   = gnt0_o | gnt1_o;
  assign sel1      = gnt1_o;
  assign sel_we    = sel1 ? we1_i    : we0_i;
  assign sel_addr  = sel1 ? addr1_i  : addr0_i;
  assign sel_be    = sel1 ? be1_i    : be0_i;
  assign sel_wdata = sel1 ? wdata1_i : wdata0_i;

  // Byte-lane bits and bits above the memory size only matter to the bounds check
  assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[31:IDX_W+2]};

`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
  assign oob = any_gnt && (sel_addr[31:OFS_W] != '0);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    mem_req_o   = any_gnt && !oob;
    mem_we_o    = mem_req_o && sel_we;
    mem_addr_o  = any_gnt ? sel_addr[IDX_W+1:2] : '0;
    mem_be_o    = mem_we_o ? sel_be : 4'b0000;
    mem_wdata_o = any_gnt ? sel_wdata : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_read  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= any_gnt;
      if (any_gnt) begin
        last_grant <= sel1;
        resp_owner <= sel1;
        resp_read  <= !sel_we;
        resp_err   <= oob;
      end
    end
  end

  // A response still in flight while reset is held is dropped rather than delivered
  always_comb begin
    rvalid0_o = resp_valid && !resp_owner && !rst_i;
    rvalid1_o = resp_valid &&  resp_owner && !rst_i;
    rdata0_o  = (rvalid0_o && resp_read && !resp_err) ? mem_rdata_i : 32'h0;
    rdata1_o  = (rvalid1_o && resp_read && !resp_err) ? mem_rdata_i : 32'h0;
  end

`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
  assign err0_o = rvalid0_o && resp_err;
  assign err1_o = rvalid1_o && resp_err;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
  localparam int IDX_W = 9;
  localparam int WORDS = 512;
`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
  localparam logic [31:0] ALIAS_EXP = 32'h0;
`else
  localparam logic [31:0] ALIAS_EXP = 32'hDEADBEEF;
`endif

  logic clk_i = 1'b0;
  logic rst_i;
  logic req0_i, we0_i, req1_i, we1_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic [3:0] be0_i, be1_i;
  logic gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
  logic [31:0] rdata0_o, rdata1_o;
  logic mem_req_o, mem_we_o;
  logic [IDX_W-1:0] mem_addr_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
  logic err0_o, err1_o;
`endif

  always #5 clk_i = ~clk_i;

  data_mem_arbiter #(.MEM_SIZE_BYTES(2048)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .be0_i(be0_i), .wdata0_i(wdata0_i),
    .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .be1_i(be1_i), .wdata1_i(wdata1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o), .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
    .err0_o(err0_o), .err1_o(err1_o),
`endif
    .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // Memory macro: 1-cycle synchronous read, byte-enabled write, garbage when not reading
  logic [31:0] mem_model [WORDS];
  logic mem_init = 1'b0;
  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < WORDS; i++) mem_model[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_req_o && mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem_model[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
    if (mem_req_o && !mem_we_o) mem_rdata_i <= mem_model[mem_addr_o];
    else mem_rdata_i <= $urandom;
  end

  // Reference model state
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] gold [WORDS];
  logic pend [2];
  logic p_we [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];
  logic [3:0] p_be [2];
  int prio;
  int last_win;
  logic rst_drv;
  logic exp_rv [2];
  logic exp_err [2];
  logic [31:0] exp_rd [2];
  logic [31:0] last_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_be[p] = be; p_wd[p] = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(3))
      0: a = $urandom;
      1: a = $urandom_range(2047);
      default: a = $urandom_range(63);
    endcase
    return a;
  endfunction

  // One clock cycle: drive, check at the falling edge, predict the next cycle
  task automatic step();
    int win;
    logic out_of_range;
    logic [31:0] a;
    logic [IDX_W-1:0] idx;
    logic nrv [2];
    logic nerr [2];
    logic [31:0] nrd [2];
    rst_i = rst_drv;
    req0_i = pend[0]; we0_i = p_we[0]; addr0_i = p_addr[0]; be0_i = p_be[0]; wdata0_i = p_wd[0];
    req1_i = pend[1]; we1_i = p_we[1]; addr1_i = p_addr[1]; be1_i = p_be[1]; wdata1_i = p_wd[1];
    last_win = -1;
    #4;
    if (rst_drv) begin
      for (int p = 0; p < 2; p++) begin exp_rv[p] = 1'b0; exp_rd[p] = 32'h0; exp_err[p] = 1'b0; end
    end
    check("rvalid0", rvalid0_o, exp_rv[0]);
    check("rvalid1", rvalid1_o, exp_rv[1]);
    check("rdata0", rdata0_o, exp_rd[0]);
    check("rdata1", rdata1_o, exp_rd[1]);
`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
    check("err0", err0_o, exp_err[0]);
    check("err1", err1_o, exp_err[1]);
`endif
    if (rvalid0_o) last_rd[0] = rdata0_o;
    if (rvalid1_o) last_rd[1] = rdata1_o;

    if (rst_drv) win = -1;
    else if (pend[0] && pend[1]) win = prio;
    else if (pend[0]) win = 0;
    else if (pend[1]) win = 1;
    else win = -1;
    check("gnt0", gnt0_o, win == 0);
    check("gnt1", gnt1_o, win == 1);

    for (int p = 0; p < 2; p++) begin nrv[p] = 1'b0; nrd[p] = 32'h0; nerr[p] = 1'b0; end
    if (win >= 0) begin
      a = p_addr[win];
      idx = a[IDX_W+1:2];
      out_of_range = 1'b0;
`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
      out_of_range = (a >= 32'd2048);
`endif
      check("mem_req", mem_req_o, !out_of_range);
      if (!out_of_range) begin
        check("mem_we", mem_we_o, p_we[win]);
        check("mem_addr", mem_addr_o, idx);
        check("mem_be", mem_be_o, p_we[win] ? p_be[win] : 4'b0000);
        if (p_we[win]) begin
          check("mem_wdata", mem_wdata_o, p_wd[win]);
          for (int b = 0; b < 4; b++)
            if (p_be[win][b]) gold[idx][8*b +: 8] = p_wd[win][8*b +: 8];
        end else begin
          nrd[win] = gold[idx];
        end
      end
      nrv[win] = 1'b1;
      nerr[win] = out_of_range;
      prio = 1 - win;
      pend[win] = 1'b0;
      last_win = win;
    end else begin
      check("mem_req_idle", mem_req_o, 1'b0);
      check("mem_wdata_idle", mem_wdata_o, 32'h0);
      if (rst_drv) begin
        check("mem_we_rst", mem_we_o, 1'b0);
        check("mem_addr_rst", mem_addr_o, '0);
        check("mem_be_rst", mem_be_o, 4'b0000);
      end
    end
    if (rst_drv) prio = 0;
    @(posedge clk_i);
    #1;
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = rst_drv ? 1'b0 : nrv[p];
      exp_rd[p] = rst_drv ? 32'h0 : nrd[p];
      exp_err[p] = rst_drv ? 1'b0 : nerr[p];
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && (pend[0] || pend[1]); k++) step();
    check("drain", {31'b0, pend[0] || pend[1]}, 32'h0);
  endtask

  task automatic do_reset();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) gold[i] = init_word(i);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 32'h0; p_be[p] = 4'h0; p_wd[p] = 32'h0;
      exp_rv[p] = 1'b0; exp_rd[p] = 32'h0; exp_err[p] = 1'b0; last_rd[p] = 32'h0;
    end
    prio = 0;
    rst_drv = 1'b1;
    rst_i = 1'b1;
    req0_i = 1'b0; we0_i = 1'b0; addr0_i = 32'h0; be0_i = 4'h0; wdata0_i = 32'h0;
    req1_i = 1'b0; we1_i = 1'b0; addr1_i = 32'h0; be1_i = 4'h0; wdata1_i = 32'h0;
    @(posedge clk_i);
    #1;
    do_reset();
    step();

    // Write then read on port 0
    set_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    step();
    set_req(0, 1'b0, 32'h10, 4'h0, 32'h0);
    step();
    step();
    check("wr_rd", last_rd[0], 32'hDEADBEEF);

    // Contention from reset: strict alternation starting with port 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) set_req(p, 1'b0, {$urandom_range(511), 2'b00}, 4'h0, 32'h0);
      step();
      check("order", last_win, i % 2);
    end
    drain();
    step();

    // Byte-enable merge
    set_req(0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    step();
    set_req(1, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    step();
    set_req(1, 1'b0, 32'h20, 4'h0, 32'h0);
    step();
    step();
    check("be_merge", last_rd[1], 32'h11BB33DD);

    // Reset while a port-1 read response is in flight
    set_req(1, 1'b0, 32'h40, 4'h0, 32'h0);
    step();
    last_rd[1] = 32'hFFFF_FFFF;
    do_reset();
    set_req(0, 1'b0, 32'h44, 4'h0, 32'h0);
    set_req(1, 1'b0, 32'h48, 4'h0, 32'h0);
    step();
    check("rst_first", last_win, 0);
    check("rst_no_rvalid1", last_rd[1], 32'hFFFF_FFFF);
    drain();
    step();

    // Out-of-range address: aliases to word 4 or flags an error
    set_req(0, 1'b0, 32'h0000_0810, 4'h0, 32'h0);
    step();
    step();
    check("alias", last_rd[0], ALIAS_EXP);

    // last_grant holds through idle cycles
    set_req(1, 1'b0, 32'h8, 4'h0, 32'h0);
    step();
    for (int i = 0; i < 3; i++) step();
    set_req(0, 1'b0, 32'hC, 4'h0, 32'h0);
    set_req(1, 1'b0, 32'h4, 4'h0, 32'h0);
    step();
    check("idle_hold", last_win, 0);
    drain();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(2) != 0)
          set_req(p, $urandom_range(1) == 1, rand_addr(), 4'($urandom), $urandom);
      rst_drv = ($urandom_range(99) == 0);
      step();
    end
    rst_drv = 1'b0;
    drain();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory (2048 bytes, 512 words) between two requesters: port 0 is the core LSU and port 1 is the debug/program loader.
- Sits between both requesters and the data memory macro.
- Sequences one access per cycle, arbitrates round-robin and routes each read response back to the requester that issued it.
- The memory has a 1-cycle synchronous read.

Parameters:
- MEM_SIZE_BYTES, 2048 (memory_pkg::DATA_MEM_SIZE_BYTES), size of the data memory in bytes; must be a power of 2.
- MEM_SIZE_WORDS, MEM_SIZE_BYTES/4, number of words in the data memory; derived, not overridable.
- IDX_W, $clog2(MEM_SIZE_WORDS), width of the word index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req0_i / req1_i  in  1  access request, port 0 / 1
- we0_i / we1_i  in  1  write enable; 0 = read
- addr0_i / addr1_i  in  32  byte address
- be0_i / be1_i  in  4  byte enables (writes only)
- wdata0_i / wdata1_i  in  32  write data
- gnt0_o / gnt1_o  out  1  access accepted this cycle
- rvalid0_o / rvalid1_o  out  1  completion/read data valid, 1 cycle after grant
- rdata0_o / rdata1_o  out  32  read data
- mem_req_o  out  1  memory access strobe
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  IDX_W  word index = addr[IDX_W+1:2]
- mem_be_o  out  4  byte enables to memory
- mem_wdata_o  out  32  write data to memory
- mem_rdata_i  in  32  memory read data, valid 1 cycle after mem_req_o

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - last_grant register <= 1, so port 0 wins the first contention.
  - resp_valid <= 0, resp_owner <= 0.
  - All rvalid*_o = 0 and all rdata*_o = 0 from the next cycle.
  - gnt*_o and mem_* are combinational and forced to 0 while rst_i=1.
- Grant logic (combinational, same cycle as request):
  - Only req0 high -> gnt0=1.
  - Only req1 high -> gnt1=1.
  - Both high -> grant the port that is NOT last_grant.
  - Neither high -> no grant, mem_req_o=0.
  - At most one gnt*_o is high in any cycle.
- Registered state: last_grant updates only on a cycle with a grant; it holds when idle.
- Memory drive: on a grant, mem_req_o=1 and mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o are muxed from the granted port.
  - mem_be_o = 4'b0000 on reads.
  - mem_wdata_o = 0 when no grant.
- Requester rule: req, we, addr, be and wdata stay stable until gnt is seen. A request may be dropped only after its grant.
- Response pipeline: granted cycle N -> resp_valid=1 and resp_owner=winner at edge N+1 -> rvalid<owner>_o=1 in cycle N+1.
  - Reads: rdata<owner>_o = mem_rdata_i in cycle N+1.
  - Writes: rvalid is still issued as a completion; rdata = 0.
  - The non-owner's rdata is 0.
- Throughput: back-to-back grants every cycle; no bubble.
  - Under continuous contention, grants strictly alternate 0,1,0,1...
- Address handling:
  - Bits [1:0] are ignored (word-aligned access; alignment is the LSU's job).
  - Bits above IDX_W+1 are ignored, so addresses alias modulo MEM_SIZE_BYTES.
- Reset mid-operation: a response pending when rst_i asserts is discarded. No rvalid is produced in the cycle after reset.

Optional Feature:
- Macro: DATA_MEM_ARB_BOUNDS_CHECK_EN.
- Defined: adds outputs err0_o/err1_o (1 bit, registered, aligned with rvalid).
  - A granted access with addr[31:$clog2(MEM_SIZE_BYTES)] != 0 is out of range.
  - It is still granted, but mem_req_o=0 (no memory access, so writes are suppressed).
  - Next cycle: rvalid=1, err=1, rdata=0.
  - Arbitration and last_grant update are unaffected.
  - err*_o reset to 0.
- Undefined: no err ports; all addresses alias as above.

Test Plan:
- Write then read, single port:
  - Stimulus: port 0 writes 0xDEADBEEF to 0x0000_0010 with be=4'hF; next cycle port 0 reads 0x10.
  - Required: gnt0 in both cycles; rvalid0 with rdata0=0xDEADBEEF 1 cycle after the read grant; mem_addr_o=4.
- Contention:
  - Stimulus: req0 and req1 held high for 6 reads from reset.
  - Required: grant order 0,1,0,1,0,1; each rvalid lands on the correct port with the matching data.
- Byte enables:
  - Stimulus: preload 0x11223344 at 0x20; port 1 writes 0xAABBCCDD with be=4'b0101; then read.
  - Required: read returns 0x11BB33DD.
- Reset mid-access:
  - Stimulus: grant a read to port 1, then assert rst_i on the next edge.
  - Required: no rvalid1; after release, first contention grants port 0.
- Aliasing or bounds:
  - Stimulus: read of 0x0000_0810.
  - Without the macro: returns the data at word 4.
  - With DATA_MEM_ARB_BOUNDS_CHECK_EN: mem_req_o=0; err0=1 with rvalid0, rdata0=0.
- Idle hold:
  - Stimulus: 3 idle cycles between a grant to port 1 and a simultaneous request.
  - Required: port 0 wins (last_grant held at 1 through idle).
